// File: rtl/acc_int_add.sv
// Two-stage registered adder with carry-out, signed overflow and valid sideband.
// Define ACC_INT_ADD_CLKGATE_EN to enable reg_en gating of the low data bits.
module acc_int_add #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int CLKGATED_BITWIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reg_en,
  input  logic                          in_valid,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          cout,
  output logic                          ovf,
  output logic                          out_valid
);

  localparam int W = DATA_PATH_BITWIDTH;
  localparam int G = CLKGATED_BITWIDTH;
  localparam logic [W-1:0] ALL_ONES = '1;
  // Mask of gated low bits; shifting by W yields zero, which covers G = 0.
  localparam logic [W-1:0] LOW_MASK = ALL_ONES >> (W - G);

  logic [W-1:0] ra, rb;
  logic [W-1:0] ra_d, rb_d, c_d;
  logic [W:0]   sum;
  logic         ovf_d;
  logic         valid_q;
  logic         load_low;

`ifdef ACC_INT_ADD_CLKGATE_EN
  logic en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_q <= 1'b0;
    else      en_q <= reg_en;
  end

  assign load_low = en_q;
`else
  logic unused_reg_en;

  assign unused_reg_en = reg_en;
  assign load_low      = 1'b1;
`endif

  // Sum uses the registered (possibly held) low bits, so the carry into bit G
  // stays consistent with the low half currently stored in ra/rb.
  always_comb begin
    sum   = {1'b0, ra} + {1'b0, rb};
    ovf_d = (ra[W-1] == rb[W-1]) && (sum[W-1] != ra[W-1]);
    ra_d  = (a & ~LOW_MASK) | ((load_low ? a : ra) & LOW_MASK);
    rb_d  = (b & ~LOW_MASK) | ((load_low ? b : rb) & LOW_MASK);
    c_d   = (sum[W-1:0] & ~LOW_MASK) | ((load_low ? sum[W-1:0] : c) & LOW_MASK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra        <= '0;
      rb        <= '0;
      c         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      valid_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ra        <= ra_d;
      rb        <= rb_d;
      c         <= c_d;
      cout      <= sum[W];
      ovf       <= ovf_d;
      valid_q   <= in_valid;
      out_valid <= valid_q;
    end
  end

endmodule

// File: tb/tb_acc_int_add.sv
// Directed self-checking bench for acc_int_add (W=32, G=16); expectations
// follow ACC_INT_ADD_CLKGATE_EN when the gated low-half behaviour differs.
module tb_acc_int_add;

  logic        clk;
  logic        rst;
  logic        reg_en;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        cout;
  logic        ovf;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

`ifdef ACC_INT_ADD_CLKGATE_EN
  localparam logic [31:0] EXP_GATED = 32'h0004_0002;
`else
  localparam logic [31:0] EXP_GATED = 32'h0005_FFFE;
`endif

  acc_int_add #(
    .DATA_PATH_BITWIDTH(32),
    .CLKGATED_BITWIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_en   (reg_en),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .cout     (cout),
    .ovf      (ovf),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    reg_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      step();
    end
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c got %h want %h", c, 32'h0); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    a = '0;
    b = '0;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_basic();
    a = 32'h1;
    b = 32'h2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b want 0", out_valid); end
    step();
    checks++; if (c !== 32'h3) begin errors++; $display("FAIL basic_c got %h want %h", c, 32'h3); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_carry_ovf();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vc [4];
    logic        vco[4];
    logic        vov[4];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 32'h0000_0000; vco[0] = 1'b1; vov[0] = 1'b0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 32'h8000_0000; vco[1] = 1'b0; vov[1] = 1'b1;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vc[2] = 32'h0000_0000; vco[2] = 1'b1; vov[2] = 1'b1;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vc[3] = 32'hFFFF_FFFE; vco[3] = 1'b1; vov[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = va[i];
      b = vb[i];
      step();
      step();
      checks++; if (c !== vc[i]) begin errors++; $display("FAIL carry_c[%0d] got %h want %h", i, c, vc[i]); end
      checks++; if (cout !== vco[i]) begin errors++; $display("FAIL carry_cout[%0d] got %b want %b", i, cout, vco[i]); end
      checks++; if (ovf !== vov[i]) begin errors++; $display("FAIL carry_ovf[%0d] got %b want %b", i, ovf, vov[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic [31:0] ps[4];
    logic        pc[4];
    logic        pv[4];
    pa[0] = 32'h0000_0005; pb[0] = 32'h0000_000A; ps[0] = 32'h0000_000F; pc[0] = 1'b0; pv[0] = 1'b1;
    pa[1] = 32'h0000_FFFF; pb[1] = 32'h0000_0001; ps[1] = 32'h0001_0000; pc[1] = 1'b0; pv[1] = 1'b0;
    pa[2] = 32'h8000_0000; pb[2] = 32'hFFFF_FFFF; ps[2] = 32'h7FFF_FFFF; pc[2] = 1'b1; pv[2] = 1'b1;
    pa[3] = 32'h1234_5678; pb[3] = 32'h1111_1111; ps[3] = 32'h2345_6789; pc[3] = 1'b0; pv[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a = pa[i];
        b = pb[i];
        in_valid = pv[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        checks++; if (c !== ps[i-1]) begin errors++; $display("FAIL b2b_c[%0d] got %h want %h", i-1, c, ps[i-1]); end
        checks++; if (cout !== pc[i-1]) begin errors++; $display("FAIL b2b_cout[%0d] got %b want %b", i-1, cout, pc[i-1]); end
        checks++; if (out_valid !== pv[i-1]) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i-1, out_valid, pv[i-1]); end
      end
    end
  endtask

  task automatic test_gating();
    int n;
    reg_en = 1'b1;
    a = 32'h1;
    b = 32'h1;
    n = 0;
    step();
    while (c !== 32'h2 && n < 8) begin
      step();
      n++;
    end
    checks++; if (c !== 32'h2) begin errors++; $display("FAIL gate_setup got %h want %h", c, 32'h2); end
    reg_en = 1'b0;
    step();
    step();
    a = 32'h0003_FFFF;
    b = 32'h0001_FFFF;
    step();
    step();
    checks++; if (c !== EXP_GATED) begin errors++; $display("FAIL gate_c got %h want %h", c, EXP_GATED); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL gate_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL gate_ovf got %b want 0", ovf); end
    reg_en = 1'b1;
    step();
    step();
    step();
    checks++; if (c !== 32'h0005_FFFE) begin errors++; $display("FAIL gate_resume got %h want %h", c, 32'h0005_FFFE); end
  endtask

  task automatic test_reset_midop();
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL midrst_c got %h want %h", c, 32'h0); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", ovf); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    step();
    step();
    rst = 1'b1;
    a = 32'h10;
    b = 32'h20;
    reg_en = 1'b1;
    step();
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL midrst_first got %h want %h", c, 32'h0); end
    step();
    step();
    step();
    checks++; if (c !== 32'h30) begin errors++; $display("FAIL midrst_result got %h want %h", c, 32'h30); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got %b want 0", out_valid); end
  endtask

  initial begin
    rst = 1'b0;
    reg_en = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_carry_ovf();
    test_back_to_back();
    test_gating();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_int_add.md
ACC_INT_ADD -- requirements
Module: acc_int_add

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 32: operand/result width W; SHALL support W >= 2.
REQ-002 Parameter CLKGATED_BITWIDTH, default 16: number G of low bits subject to enable-gated update; SHALL support 0 <= G <= W.
REQ-003 clk  input  1  clock; all registers SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 reg_en  input  1  update enable for the G low bits of the input and output registers.
REQ-006 in_valid  input  1  operand-valid sideband.
REQ-007 a  input  W  operand A, unsigned or two's complement.
REQ-008 b  input  W  operand B, unsigned or two's complement.
REQ-009 c  output  W  registered sum.
REQ-010 cout  output  1  registered unsigned carry-out of the W-bit sum.
REQ-011 ovf  output  1  registered signed overflow of the W-bit sum.
REQ-012 out_valid  output  1  registered valid aligned with c/cout/ovf.

Function
REQ-013 Two register stages SHALL be used: input stage (ra, rb) and output stage (c, cout, ovf).
REQ-014 Sum SHALL be {cout,s} = ra + rb, computed in W+1 bits; c = s mod 2^W.
REQ-015 ovf SHALL be 1 iff ra[W-1] == rb[W-1] and s[W-1] != ra[W-1].
REQ-016 Latency: a/b sampled at edge k SHALL appear on c/cout/ovf after edge k+1 when all bits are enabled.
REQ-017 out_valid SHALL equal in_valid delayed by two edges; data registers SHALL load every edge regardless of in_valid.
REQ-018 reg_en SHALL be registered into en_q on every edge.
REQ-019 Upper bits [W-1:G] of ra, rb, c SHALL load on every edge.
REQ-020 Low bits [G-1:0] of ra, rb, c SHALL load on an edge only when en_q = 1; otherwise they SHALL hold.
REQ-021 cout and ovf SHALL load on every edge.
REQ-022 The carry into bit G SHALL come from the currently held low bits of ra/rb, so the upper sum is consistent with the held low half.
REQ-023 G = 0: reg_en SHALL have no effect; G = W: all data bits are gated, while cout and ovf still load every edge.

Reset
REQ-024 rst = 0 SHALL immediately clear ra, rb, c, cout, ovf, en_q, out_valid and the valid pipeline to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight data; the first post-reset result SHALL appear two edges after release, with low bits held at 0 until en_q = 1.
REQ-026 After release, registers SHALL resume loading at the first rising edge with rst = 1.

Configuration
REQ-027 Macro ACC_INT_ADD_CLKGATE_EN defined: low-bit gating per REQ-018..REQ-023 SHALL be active.
REQ-028 Macro undefined: reg_en SHALL be ignored, all bits SHALL load every edge and en_q SHALL be omitted; the port list SHALL be unchanged.

Verification (W=32, G=16, macro defined unless noted)
REQ-029 Hold rst=0 with random a/b -> c=0, cout=0, ovf=0, out_valid=0.
REQ-030 reg_en=1 held, a=0x00000001, b=0x00000002, in_valid pulse -> c=0x00000003 and out_valid=1 two edges later.
REQ-031 a=0xFFFFFFFF, b=0x00000001 -> c=0, cout=1, ovf=0; a=0x7FFFFFFF, b=0x00000001 -> c=0x80000000, cout=0, ovf=1.
REQ-032 reg_en=1 with a=b=0x00000001 until c=0x00000002, then reg_en=0 for 2+ edges, then a=0x0003FFFF, b=0x0001FFFF -> c=0x00040002, cout=0.
REQ-033 Macro undefined, same stimulus as REQ-032 -> c=0x0005FFFE.
REQ-034 Assert rst=0 between input sample and result -> outputs clear immediately; after release, a=0x10, b=0x20 with reg_en=1 -> c=0x00000030.
